// File: rtl/cellrv32_cpu_cp_dispatch_if.sv
// Bundle of the CPU-side request/response signals and the co-processor
// issue/collect signals handled by cellrv32_cpu_cp_dispatch.
// slave  : the dispatch controller's view.
// master : the view of whatever drives the CPU and co-processor side.
interface cellrv32_cpu_cp_dispatch_if #(
    parameter int XLEN   = 32,
    parameter int NUM_CP = 4,
    parameter int SEL_W  = (NUM_CP > 1) ? $clog2(NUM_CP) : 1
);
    // CPU side
    logic                   req_i;
    logic [SEL_W-1:0]       sel_i;
    logic [2:0]             funct3_i;
    logic [XLEN-1:0]        rs1_i;
    logic [XLEN-1:0]        rs2_i;
    logic                   trap_i;
    logic                   busy_o;
    logic                   done_o;
    logic [XLEN-1:0]        res_o;
    logic                   err_o;

    // co-processor side
    logic [NUM_CP-1:0]      cp_start_o;
    logic [2:0]             cp_funct3_o;
    logic [XLEN-1:0]        cp_rs1_o;
    logic [XLEN-1:0]        cp_rs2_o;
    logic [NUM_CP*XLEN-1:0] cp_res_i;
    logic [NUM_CP-1:0]      cp_valid_i;

    modport slave (
        input  req_i, sel_i, funct3_i, rs1_i, rs2_i, trap_i,
        input  cp_res_i, cp_valid_i,
        output busy_o, done_o, res_o, err_o,
        output cp_start_o, cp_funct3_o, cp_rs1_o, cp_rs2_o
    );

    modport master (
        output req_i, sel_i, funct3_i, rs1_i, rs2_i, trap_i,
        output cp_res_i, cp_valid_i,
        input  busy_o, done_o, res_o, err_o,
        input  cp_start_o, cp_funct3_o, cp_rs1_o, cp_rs2_o
    );
endinterface

// File: rtl/cellrv32_cpu_cp_dispatch.sv
// Co-processor dispatch: latches a CPU request, pulses start to the selected
// slot, waits for its valid, returns the result one cycle after the valid's
// follow-up cycle, and supervises the operation with a watchdog.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | no operation; accept req_i, flag illegal slot selects
// S_WAIT    | start issued, waiting for the selected slot's valid
// S_CAPTURE | valid seen; sample the slot result, return it unless trapped
// S_DRAIN   | trapped while waiting; swallow the aborting slot's valid
module cellrv32_cpu_cp_dispatch #(
    parameter int XLEN    = 32,
    parameter int NUM_CP  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    cellrv32_cpu_cp_dispatch_if.slave     bus
);

    localparam int SEL_W = (NUM_CP > 1) ? $clog2(NUM_CP) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  sel_q;
    logic              latch;
    logic              sel_legal;
    logic              valid_sel;
    logic [XLEN-1:0]   res_sel;
    logic [NUM_CP-1:0] start_d;
    logic              done_d;
    logic              err_d;
    logic [XLEN-1:0]   res_d;

    assign sel_legal  = (32'(bus.sel_i) < 32'(NUM_CP));
    assign bus.busy_o = (state_q != S_IDLE);

    // Route the held slot's valid and result; unselected slots are invisible.
    always_comb begin
        valid_sel = 1'b0;
        res_sel   = '0;
        for (int i = 0; i < NUM_CP; i++) begin
            if (sel_q == SEL_W'(i)) begin
                valid_sel = bus.cp_valid_i[i];
                res_sel   = bus.cp_res_i[i*XLEN +: XLEN];
            end
        end
    end

    // Next-state, watchdog and registered-output decisions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        start_d = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        res_d   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_i) begin
                    latch = 1'b1;
                    if (!sel_legal) begin
                        err_d = 1'b1;
                    end else begin
                        for (int i = 0; i < NUM_CP; i++) begin
                            if (bus.sel_i == SEL_W'(i)) start_d[i] = 1'b1;
                        end
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            S_WAIT: begin
                // saturate so a trap at the limit cannot wrap the drain budget
                if (cnt_q != CNT_LIMIT) cnt_d = cnt_q + CNT_W'(1);
                if (valid_sel) begin
                    state_d = S_CAPTURE;
                end else if (bus.trap_i) begin
                    state_d = S_DRAIN;
                end else if (cnt_q == CNT_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_CAPTURE: begin
                if (!bus.trap_i) begin
                    done_d = 1'b1;
                    res_d  = res_sel;
                end
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (cnt_q != CNT_LIMIT) cnt_d = cnt_q + CNT_W'(1);
                if (valid_sel || (cnt_q == CNT_LIMIT)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, watchdog and all outputs are registered; reset clears them at once.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            sel_q           <= '0;
            bus.cp_funct3_o <= '0;
            bus.cp_rs1_o    <= '0;
            bus.cp_rs2_o    <= '0;
            bus.cp_start_o  <= '0;
            bus.done_o      <= 1'b0;
            bus.err_o       <= 1'b0;
            bus.res_o       <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bus.cp_start_o <= start_d;
            bus.done_o     <= done_d;
            bus.err_o      <= err_d;
            bus.res_o      <= res_d;
            if (latch) begin
                sel_q           <= bus.sel_i;
                bus.cp_funct3_o <= bus.funct3_i;
                bus.cp_rs1_o    <= bus.rs1_i;
                bus.cp_rs2_o    <= bus.rs2_i;
            end
        end
    end

endmodule
